// File: rtl/commit_trace_packer.sv
// Buffers retirement records in a small FIFO and serializes each one as 3 or 4 32-bit words.
// Output latency is one cycle into an empty FIFO; out_ready low holds the word; a full FIFO drops and counts.
module commit_trace_packer #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        trace_valid,
  input  logic        trace_excpt,
  input  logic [2:0]  trace_priv_mode,
  input  logic [31:0] trace_pc,
  input  logic [31:0] trace_inst,
  input  logic [4:0]  trace_wrdst,
  input  logic [31:0] trace_wrdata,
  input  logic        trace_wrenx,
  input  logic        trace_wrenf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [15:0] drop_count,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW + 1)'(1);

  typedef struct packed {
    logic [31:0] hdr;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] wrdata;
    logic        has_data;
  } rec_t;

  typedef enum logic [2:0] {IDLE, HDR, PC, INST, DATA} state_t;

  rec_t          mem [DEPTH];
  rec_t          head;
  rec_t          new_rec;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [15:0]   seq;
  logic          drop_pending;
  state_t        state;
  state_t        state_nxt;
  logic          retire;
  logic          xfer;
  logic          pop;
  logic          push;
  logic          drop;
  logic          more;

  assign retire = enable & trace_valid;
  assign xfer   = out_valid & out_ready;
  assign head   = mem[rd_ptr];
  // Popping on the final word frees a slot that a same-cycle retirement may take.
  assign pop    = xfer & (((state == INST) & ~head.has_data) | (state == DATA));
  assign push   = retire & ((count != FULL) | pop);
  assign drop   = retire & ~push;
  assign more   = (count > ONE) | push;
  assign busy   = (count != '0) | (state != IDLE);

  assign new_rec = '{
    hdr:      {4'hA, trace_priv_mode, trace_excpt, trace_wrenx, trace_wrenf,
               trace_wrdst, drop_pending, seq},
    pc:       trace_pc,
    inst:     trace_inst,
    wrdata:   trace_wrdata,
    has_data: trace_wrenx | trace_wrenf
  };

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) | push) state_nxt = HDR;
      end
      HDR: begin
        out_valid = 1'b1;
        out_data  = head.hdr;
        if (xfer) state_nxt = PC;
      end
      PC: begin
        out_valid = 1'b1;
        out_data  = head.pc;
        if (xfer) state_nxt = INST;
      end
      INST: begin
        out_valid = 1'b1;
        out_data  = head.inst;
        out_last  = ~head.has_data;
        if (xfer) begin
          if (head.has_data) state_nxt = DATA;
          else               state_nxt = more ? HDR : IDLE;
        end
      end
      DATA: begin
        out_valid = 1'b1;
        out_data  = head.wrdata;
        out_last  = 1'b1;
        if (xfer) state_nxt = more ? HDR : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      seq          <= '0;
      drop_pending <= 1'b0;
      drop_count   <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      if (retire) seq <= seq + 16'd1;
      if (drop) begin
        drop_pending <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end else if (push) begin
        drop_pending <= 1'b0;
      end
    end
  end

  // Storage is not reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clock) begin
    if (reset && push) mem[wr_ptr] <= new_rec;
  end

endmodule

// File: tb/tb_commit_trace_packer.sv
module tb_commit_trace_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        trace_valid;
  logic        trace_excpt;
  logic [2:0]  trace_priv_mode;
  logic [31:0] trace_pc;
  logic [31:0] trace_inst;
  logic [4:0]  trace_wrdst;
  logic [31:0] trace_wrdata;
  logic        trace_wrenx;
  logic        trace_wrenf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [15:0] drop_count;
  logic        busy;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  commit_trace_packer #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset), .enable(enable), .trace_valid(trace_valid),
    .trace_excpt(trace_excpt), .trace_priv_mode(trace_priv_mode), .trace_pc(trace_pc),
    .trace_inst(trace_inst), .trace_wrdst(trace_wrdst), .trace_wrdata(trace_wrdata),
    .trace_wrenx(trace_wrenx), .trace_wrenf(trace_wrenf), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .drop_count(drop_count), .busy(busy)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_rec(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] wrdata,
                         input logic [4:0] wrdst, input logic [2:0] priv, input logic excpt,
                         input logic wenx, input logic wenf);
    trace_pc        = pc;
    trace_inst      = inst;
    trace_wrdata    = wrdata;
    trace_wrdst     = wrdst;
    trace_priv_mode = priv;
    trace_excpt     = excpt;
    trace_wrenx     = wenx;
    trace_wrenf     = wenf;
  endtask

  // Checks the word presented this cycle, then advances one clock (out_ready assumed high).
  task automatic expect_word(input string tag, input logic [31:0] d, input logic last);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_dat"}, out_data, d);
    chk({tag, "_last"}, 32'(out_last), 32'(last));
    tick;
  endtask

  task automatic expect_rec(input string tag, input logic [31:0] hdr, input logic [31:0] pc,
                            input logic [31:0] inst, input logic has_data, input logic [31:0] data);
    expect_word({tag, "_hdr"}, hdr, 1'b0);
    expect_word({tag, "_pc"}, pc, 1'b0);
    expect_word({tag, "_inst"}, inst, ~has_data);
    if (has_data) expect_word({tag, "_data"}, data, 1'b1);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 64 && busy; i++) tick;
    chk({tag, "_drain_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset       = 1'b0;
    enable      = 1'b0;
    trace_valid = 1'b0;
    out_ready   = 1'b0;
    set_rec(32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Reset, with a retirement presented that must be ignored
    tick;
    tick;
    enable      = 1'b1;
    trace_valid = 1'b1;
    tick;
    trace_valid = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    reset     = 1'b1;
    out_ready = 1'b1;
    tick;
    chk("rst_rel_valid", 32'(out_valid), 32'd0);

    // Single 4-word record, header visible the cycle after acceptance
    set_rec(32'h8000_0000, 32'h0010_0093, 32'h1, 5'd1, 3'd3, 1'b0, 1'b1, 1'b0);
    trace_valid = 1'b1;
    tick;
    trace_valid = 1'b0;
    expect_rec("single", 32'hA682_0000, 32'h8000_0000, 32'h0010_0093, 1'b1, 32'h1);
    chk("single_idle_vld", 32'(out_valid), 32'd0);
    chk("single_idle_busy", 32'(busy), 32'd0);

    // 3-word record followed back to back by an FP-writeback record
    set_rec(32'h100, 32'h13, 32'h0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    trace_valid = 1'b1;
    tick;
    set_rec(32'h200, 32'h33, 32'hDEAD_BEEF, 5'd5, 3'd1, 1'b0, 1'b0, 1'b1);
    expect_word("a_hdr", 32'hA100_0001, 1'b0);
    trace_valid = 1'b0;
    expect_word("a_pc", 32'h100, 1'b0);
    expect_word("a_inst", 32'h13, 1'b1);
    expect_rec("b", 32'hA24A_0002, 32'h200, 32'h33, 1'b1, 32'hDEAD_BEEF);
    chk("b_idle_vld", 32'(out_valid), 32'd0);

    // Overflow: 6 retires into a 4-deep FIFO with output stalled
    reset = 1'b0;
    tick;
    reset     = 1'b1;
    out_ready = 1'b0;
    set_rec(32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      trace_pc    = 32'h1000 + 32'(i);
      trace_inst  = 32'h2000 + 32'(i);
      trace_valid = 1'b1;
      tick;
    end
    // Disabled retirements: no capture, no drop, no seq advance
    enable   = 1'b0;
    trace_pc = 32'hBAD;
    repeat (3) tick;
    trace_valid = 1'b0;
    enable      = 1'b1;
    chk("ovf_drops", 32'(drop_count), 32'd2);
    chk("ovf_stall_vld", 32'(out_valid), 32'd1);
    chk("ovf_stall_dat", out_data, 32'hA000_0000);
    chk("ovf_stall_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    expect_word("f0_hdr", 32'hA000_0000, 1'b0);
    expect_word("f0_pc", 32'h1000, 1'b0);
    // Retire while full, in the same cycle as the final word transfers
    trace_pc    = 32'h1006;
    trace_inst  = 32'h2006;
    trace_valid = 1'b1;
    expect_word("f0_inst", 32'h2000, 1'b1);
    trace_valid = 1'b0;
    chk("full_pop_drops", 32'(drop_count), 32'd2);
    expect_rec("f1", 32'hA000_0001, 32'h1001, 32'h2001, 1'b0, 32'h0);
    expect_rec("f2", 32'hA000_0002, 32'h1002, 32'h2002, 1'b0, 32'h0);
    expect_rec("f3", 32'hA000_0003, 32'h1003, 32'h2003, 1'b0, 32'h0);
    expect_rec("f6", 32'hA001_0006, 32'h1006, 32'h2006, 1'b0, 32'h0);
    chk("ovf_idle_vld", 32'(out_valid), 32'd0);

    // Reset asserted while the PC word is on the output
    set_rec(32'h300, 32'h44, 32'h7, 5'd2, 3'd3, 1'b0, 1'b1, 1'b0);
    trace_valid = 1'b1;
    tick;
    trace_valid = 1'b0;
    expect_word("mid_hdr", 32'hA684_0007, 1'b0);
    chk("mid_pc", out_data, 32'h300);
    reset       = 1'b0;
    trace_valid = 1'b1;
    tick;
    chk("mid_rst_vld", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_drops", 32'(drop_count), 32'd0);
    chk("mid_rst_dat", out_data, 32'h0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    reset       = 1'b1;
    trace_valid = 1'b0;
    tick;
    tick;
    chk("mid_post_vld", 32'(out_valid), 32'd0);
    chk("mid_post_busy", 32'(busy), 32'd0);
    set_rec(32'h400, 32'h55, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    trace_valid = 1'b1;
    tick;
    trace_valid = 1'b0;
    expect_rec("post", 32'hA000_0000, 32'h400, 32'h55, 1'b0, 32'h0);

    // Sequence wrap: 65535 burst retires, then seq 0xFFFF, then seq 0x0000
    reset = 1'b0;
    tick;
    reset = 1'b1;
    set_rec(32'h0, 32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    trace_valid = 1'b1;
    repeat (65535) tick;
    trace_valid = 1'b0;
    drain("burst");
    trace_valid = 1'b1;
    tick;
    trace_valid = 1'b0;
    chk("wrap_x_vld", 32'(out_valid), 32'd1);
    chk("wrap_x_seq", {16'h0, out_data[15:0]}, 32'h0000_FFFF);
    drain("wrap_x");
    set_rec(32'h500, 32'h66, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    trace_valid = 1'b1;
    tick;
    trace_valid = 1'b0;
    expect_rec("wrap_y", 32'hA000_0000, 32'h500, 32'h66, 1'b0, 32'h0);

    // Disabled capture with an empty FIFO produces no words
    enable      = 1'b0;
    trace_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("dis_vld", 32'(out_valid), 32'd0);
    end
    chk("dis_busy", 32'(busy), 32'd0);
    trace_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/commit_trace_packer.md
COMMIT_TRACE_PACKER -- requirements
Module: commit_trace_packer

Interface
REQ-001 Parameter: DEPTH, default 4, record FIFO depth; power of two, >= 2.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising clock edge.
REQ-004 enable  input  1  capture enable; 0 = ignore retirements.
REQ-005 trace_valid  input  1  retirement record present this cycle.
REQ-006 trace_excpt  input  1  retirement took exception.
REQ-007 trace_priv_mode  input  3  privilege mode at retirement.
REQ-008 trace_pc  input  32  retired PC.
REQ-009 trace_inst  input  32  retired instruction bits.
REQ-010 trace_wrdst  input  5  destination register index.
REQ-011 trace_wrdata  input  32  writeback data.
REQ-012 trace_wrenx, trace_wrenf  input  1 each  integer / FP writeback enables.
REQ-013 out_valid  output  1  out_data holds a valid word.
REQ-014 out_ready  input  1  downstream accepts word; transfer when out_valid & out_ready.
REQ-015 out_data  output  32  packed trace word.
REQ-016 out_last  output  1  current word is final word of its record.
REQ-017 drop_count  output  16  saturating count of dropped records.
REQ-018 busy  output  1  FIFO non-empty or serializer not IDLE.

Function
REQ-019 Retirement accepted when enable & trace_valid & (fifo_count < DEPTH, or final word of head record transfers same cycle); accepted record written to FIFO tail at that edge.
REQ-020 enable & trace_valid with FIFO full and no same-cycle final-word transfer: record dropped, drop_count += 1 saturating at 16'hFFFF, sticky drop_pending set.
REQ-021 seq (16-bit) increments by 1 for every enable & trace_valid cycle, accepted or dropped; wraps 16'hFFFF -> 0; record captures pre-increment value.
REQ-022 enable = 0: no capture, no drop, seq unchanged; serializer keeps draining.
REQ-023 Word 0 (header): [31:28]=4'hA, [27:25]=priv_mode, [24]=excpt, [23]=wrenx, [22]=wrenf, [21:17]=wrdst, [16]=drop_pending at capture, [15:0]=seq.
REQ-024 Accepting a record clears drop_pending, unless the same cycle also sets it (cannot happen; accept and drop are exclusive).
REQ-025 Word 1 = pc; Word 2 = inst; Word 3 = wrdata, emitted only if wrenx | wrenf.
REQ-026 Record length 4 words if wrenx | wrenf, else 3; out_last = 1 on Word 3 or Word 2 respectively.
REQ-027 Serializer FSM states IDLE, HDR, PC, INST, DATA; IDLE->HDR when FIFO non-empty; HDR->PC->INST on transfer; INST->DATA on transfer if write enable set, else pop; DATA on transfer pops.
REQ-028 On pop: -> HDR if FIFO holds another record (excluding popped), else IDLE; no bubble between back-to-back records.
REQ-029 out_valid = (state != IDLE); out_data/out_last combinational from FIFO head and state; held stable while out_valid & !out_ready.
REQ-030 Latency: record accepted at edge N into empty FIFO with IDLE serializer gives out_valid high, Word 0, in cycle after edge N.
REQ-031 Simultaneous push and pop: fifo_count unchanged; push to tail, pop from head, no corruption at pointer wrap.

Reset
REQ-032 reset = 0 at a rising edge: state IDLE, FIFO empty, pointers 0, seq = 0, drop_pending = 0, drop_count = 0.
REQ-033 During and after reset: out_valid = 0, out_last = 0, busy = 0, out_data = 0; in-flight records discarded, no partial record emitted after release.
REQ-034 Inputs ignored while reset = 0.

Verification
REQ-035 Single retire pc=0x80000000, inst=0x00100093, wrenx=1, wrdst=1, wrdata=1, priv=3, out_ready=1 -> words 0xA6820000, 0x80000000, 0x00100093, 0x00000001; out_last on 4th only.
REQ-036 Retire with wrenx=wrenf=0 -> exactly 3 words, out_last on inst word, next record's header follows next cycle.
REQ-037 DEPTH=4, out_ready=0, 6 consecutive retires -> 4 accepted, drop_count=2; after ready, 5th retire header bit16=1, seq=6; drained seqs 0,1,2,3,6.
REQ-038 FIFO full, retire in same cycle as final-word transfer -> accepted, drop_count unchanged.
REQ-039 Assert reset mid-record (during PC word) -> next cycle out_valid=0, busy=0, drop_count=0; first post-reset record has seq=0.
REQ-040 Seq wrap: 65537 retires with out_ready=1 -> last header seq=0x0000; enable=0 cycles with trace_valid=1 produce no words and no drops.
